// File: rtl/l2_mem_responder_pkg.sv
// Shared types for the L2 memory-side responder: line/word types, FSM states and request op.
// Imported by the responder top and its line storage.

package l2_mem_responder_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_8words;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        DONE
    } lc3b_mem_state;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } lc3b_mem_op;

    localparam int unsigned LINE_BITS   = 128;
    localparam int unsigned OFFSET_BITS = 4;
    localparam int unsigned CNT_BITS    = 8;

    // A simultaneous read and write is served as a write.
    function automatic lc3b_mem_op decode_op(input logic write);
        return write ? OP_WRITE : OP_READ;
    endfunction

endpackage

// File: rtl/l2_mem_array.sv
// Line storage for the L2 memory responder: synchronous write, registered read.
// The storage itself is not reset; only the read register is.

module l2_mem_array
    import l2_mem_responder_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 12,
    parameter int unsigned WIDTH      = LINE_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic [WIDTH-1:0]      rd_data
);

    localparam int unsigned DEPTH = 2 ** INDEX_BITS;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read data is held between reads so the requester can sample it after resp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/l2_mem_responder.sv
// Memory-side responder for the L2 line interface: accepts a 128-bit line read or write,
// answers with a one-cycle resp after LATENCY cycles, then sits out one cycle before re-arming.

module l2_mem_responder
    import l2_mem_responder_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 12,
    parameter int unsigned LATENCY    = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [15:0]  adr,
    input  logic [127:0] wdata,
    output logic [127:0] rdata,
    output logic         resp,
    output logic         busy
);

    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(LATENCY - 1);

    lc3b_mem_state           state_q, state_d;
    logic [CNT_BITS-1:0]     cnt_q, cnt_d;
    logic [INDEX_BITS-1:0]   idx_q, idx_d;
    lc3b_mem_op              op_q, op_d;
    lc3b_8words              wdata_q, wdata_d;

    logic                    req;
    logic [INDEX_BITS-1:0]   adr_idx;
    logic                    rd_en;
    logic                    wr_en;
    logic                    unused_adr;

    assign req        = mem_read | mem_write;
    // Upper address bits alias and the byte offset within the line is ignored.
    assign adr_idx    = adr[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];
    assign unused_adr = ^adr;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latches and latency counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            op_q    <= OP_READ;
            wdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = adr_idx;
                    op_d    = decode_op(mem_write);
                    wdata_d = wdata;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                // A dropped request abandons the transaction with no side effects.
                if (!req) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q <= 1) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs and storage control
    always_comb begin
        resp  = (state_q == RESP);
        busy  = (state_q == WAIT) || (state_q == RESP);
        // Read is captured on the edge entering RESP; idx_d covers the LATENCY=1 path from IDLE.
        rd_en = (state_q != RESP) && (state_d == RESP) && (op_d == OP_READ);
        wr_en = (state_q == RESP) && (op_q == OP_WRITE);
    end

    l2_mem_array #(
        .INDEX_BITS (INDEX_BITS),
        .WIDTH      (LINE_BITS)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_idx  (idx_q),
        .wr_data (wdata_q),
        .rd_en   (rd_en),
        .rd_idx  (idx_d),
        .rd_data (rdata)
    );

endmodule

// File: tb/tb_l2_mem_responder.sv
// Bench for l2_mem_responder: two instances (long latency / LATENCY=1 with aliasing index),
// directed scenarios followed by random transactions against a line-level reference model.

module tb_l2_mem_responder;

    localparam int unsigned L0  = 10;
    localparam int unsigned IB0 = 12;
    localparam int unsigned L1  = 1;
    localparam int unsigned IB1 = 8;

    localparam logic [127:0] DEAD_BEEF = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    localparam logic [127:0] FIVES     = {4{32'h5555_5555}};

    logic                  clk;
    logic                  rst_n;
    logic [1:0]            mem_read;
    logic [1:0]            mem_write;
    logic [1:0][15:0]      adr;
    logic [1:0][127:0]     wdata;
    logic [1:0][127:0]     rdat;
    logic [1:0]            rsp;
    logic [1:0]            bsy;

    int unsigned           cyc;
    int unsigned           checks;
    int unsigned           errors;

    logic [127:0]          mdl [int];
    logic [127:0]          mdl_rdata [2];

    l2_mem_responder #(
        .INDEX_BITS (IB0),
        .LATENCY    (L0)
    ) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read[0]),
        .mem_write (mem_write[0]),
        .adr       (adr[0]),
        .wdata     (wdata[0]),
        .rdata     (rdat[0]),
        .resp      (rsp[0]),
        .busy      (bsy[0])
    );

    l2_mem_responder #(
        .INDEX_BITS (IB1),
        .LATENCY    (L1)
    ) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read[1]),
        .mem_write (mem_write[1]),
        .adr       (adr[1]),
        .wdata     (wdata[1]),
        .rdata     (rdat[1]),
        .resp      (rsp[1]),
        .busy      (bsy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int unsigned lat(input int u);
        return (u == 0) ? L0 : L1;
    endfunction

    // Line number as memory sees it: byte address / 16, wrapped to the storage depth.
    function automatic int line_key(input int u, input logic [15:0] a);
        int unsigned ib;
        ib = (u == 0) ? IB0 : IB1;
        return u * 65536 + int'((int'(a) / 16) % (1 << ib));
    endfunction

    function automatic logic [127:0] mdl_get(input int key);
        return mdl.exists(key) ? mdl[key] : '0;
    endfunction

    // One request from acceptance to the idle cycle after DONE.
    // abort_at >= 0 drops the request at that negedge of the wait phase.
    task automatic xact(input int u, input bit rq, input bit wq, input logic [15:0] a,
                        input logic [127:0] d, input int abort_at, input bit hold_done);
        int unsigned lt;
        int unsigned n;
        int unsigned period;
        bit          seen;
        int          key;
        lt     = lat(u);
        key    = line_key(u, a);
        seen   = 1'b0;
        period = 0;
        @(negedge clk);
        mem_read[u]  = rq;
        mem_write[u] = wq;
        adr[u]       = a;
        wdata[u]     = d;
        @(posedge clk);
        #1;
        n = cyc;
        for (int i = 0; i < int'(lt) + 4; i++) begin
            @(negedge clk);
            if (rsp[u]) begin
                seen   = 1'b1;
                period = cyc + 1;
                break;
            end
            if (i == 0) check("busy_in_flight", 128'(bsy[u]), 128'(1));
            if (abort_at >= 0 && i == abort_at + 1) check("abort_idle", 128'(bsy[u]), 128'(0));
            if (abort_at >= 0 && i == abort_at) begin
                mem_read[u]  = 1'b0;
                mem_write[u] = 1'b0;
            end else if (abort_at < 0 || i < abort_at) begin
                adr[u]   = 16'($urandom);
                wdata[u] = {4{$urandom}};
            end
        end
        if (abort_at >= 0) begin
            check("abort_no_resp", 128'(seen), 128'(0));
        end else begin
            check("resp_seen", 128'(seen), 128'(1));
            if (seen) check("resp_cycle", 128'(period), 128'(n + lt));
            if (wq) mdl[key] = d;
            else mdl_rdata[u] = mdl_get(key);
            if (seen) check("rdata", rdat[u], mdl_rdata[u]);
            if (!hold_done) begin
                mem_read[u]  = 1'b0;
                mem_write[u] = 1'b0;
            end
            @(negedge clk);
            check("done_no_resp", 128'(rsp[u]), 128'(0));
            check("done_not_busy", 128'(bsy[u]), 128'(0));
            mem_read[u]  = 1'b0;
            mem_write[u] = 1'b0;
            @(negedge clk);
            check("idle_no_reserve", 128'(rsp[u] | bsy[u]), 128'(0));
        end
    endtask

    // Read held continuously: the second service must start right after the DONE cycle.
    task automatic back_to_back(input logic [15:0] a);
        int unsigned n;
        int unsigned p1;
        int unsigned p2;
        int unsigned hits;
        logic        prev;
        hits = 0;
        p1   = 0;
        p2   = 0;
        prev = 1'b0;
        @(negedge clk);
        mem_read[0] = 1'b1;
        adr[0]      = a;
        @(posedge clk);
        #1;
        n = cyc;
        for (int i = 0; i < 2 * int'(L0) + 10 && hits < 2; i++) begin
            @(negedge clk);
            if (rsp[0] && !prev) begin
                hits++;
                if (hits == 1) p1 = cyc + 1;
                else p2 = cyc + 1;
            end
            prev = rsp[0];
        end
        mem_read[0] = 1'b0;
        mdl_rdata[0] = mdl_get(line_key(0, a));
        check("b2b_hits", 128'(hits), 128'(2));
        check("b2b_first", 128'(p1), 128'(n + L0));
        check("b2b_gap", 128'(p2 - p1), 128'(L0 + 2));
        check("b2b_rdata", rdat[0], mdl_rdata[0]);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bit          stray;
        int          op;
        int          u;
        int          ab;
        logic [15:0] a;
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        mem_read     = '0;
        mem_write    = '0;
        adr          = '0;
        wdata        = '0;
        mdl_rdata[0] = '0;
        mdl_rdata[1] = '0;

        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_resp", 128'(rsp[k]), 128'(0));
            check("reset_busy", 128'(bsy[k]), 128'(0));
            check("reset_rdata", rdat[k], 128'(0));
        end
        rst_n = 1'b1;

        xact(0, 1, 0, 16'h0040, '0, -1, 0);
        xact(0, 0, 1, 16'h1230, DEAD_BEEF, -1, 0);
        xact(0, 1, 0, 16'h123F, '0, -1, 0);
        back_to_back(16'h1230);
        xact(0, 1, 0, 16'h1234, '0, -1, 1);

        // Abort a write after a few wait cycles: old data must survive.
        xact(0, 0, 1, 16'h1230, ~DEAD_BEEF, 3, 0);
        xact(0, 1, 0, 16'h1230, '0, -1, 0);

        // Reset during the wait phase of a write.
        @(negedge clk);
        mem_write[0] = 1'b1;
        adr[0]       = 16'h1230;
        wdata[0]     = FIVES;
        @(posedge clk);
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 128'(bsy[0]), 128'(1));
        rst_n = 1'b0;
        #1;
        check("rst_resp", 128'(rsp[0]), 128'(0));
        check("rst_busy", 128'(bsy[0]), 128'(0));
        check("rst_rdata", rdat[0], 128'(0));
        mdl_rdata[0] = '0;
        mdl_rdata[1] = '0;
        mem_write[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (L0 + 2) begin
            @(negedge clk);
            stray |= rsp[0];
        end
        check("rst_no_resp", 128'(stray), 128'(0));
        xact(0, 1, 0, 16'h1230, '0, -1, 0);

        // LATENCY=1 instance: simultaneous read+write, then aliasing of upper address bits.
        xact(1, 0, 1, 16'h0020, DEAD_BEEF, -1, 0);
        xact(1, 1, 0, 16'h0020, '0, -1, 0);
        xact(1, 1, 1, 16'h0010, FIVES, -1, 0);
        xact(1, 1, 0, 16'h0010, '0, -1, 0);
        xact(1, 0, 1, 16'hF230, ~FIVES, -1, 0);
        xact(1, 1, 0, 16'h0234, '0, -1, 1);

        for (int it = 0; it < 60; it++) begin
            u  = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 2));
            a  = {(u == 1) ? 4'($urandom) : 4'h2, 8'($urandom_range(0, 3)), 4'($urandom)};
            ab = -1;
            if (u == 0 && $urandom_range(0, 9) == 0) ab = int'($urandom_range(1, L0 - 2));
            xact(u, op != 1, op != 0, a, {4{$urandom}}, ab, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
